debug_scan_bridge: RTL and testbench

Parametrised, single-clock debug scan engine that joins the virtual-JTAG strobes to the CPU debug logic. It sits between the JTAG hub and the OCI/break/trace units. It captures one of `NCH` status words into a shift register and shifts it through `tdi`/`tdo`. On update it presents the shifted word as `jdo` with a one-cycle per-channel action or no-action pulse. Unlike the fixed 2-bit/38-bit slave, it is generic in instruction width, data width and channel count. It also adds an acknowledged update handshake with overrun detection.

---
 rtl/debug_scan_pkg.sv | 9 +
 rtl/debug_scan_shreg.sv | 29 ++
 rtl/debug_scan_bridge.sv | 106 ++++++++++
 tb/tb_debug_scan_bridge.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/debug_scan_pkg.sv
// Shared types and constants for the debug scan bridge.
package debug_scan_pkg;
  typedef enum logic [1:0] {UPD_IDLE, UPD_PULSE, UPD_WAIT} upd_state_t;

  localparam int IR_W_MIN    = 2;
  localparam int DR_W_MIN    = 8;
  localparam int IRO_PENDING = 0;
  localparam int IRO_OVERRUN = 1;
endpackage

// File: rtl/debug_scan_shreg.sv
// Capture/shift data register: loads the selected channel's status word and
// shifts it LSB first between tdi and tdo.
module debug_scan_shreg #(
  parameter int IR_W = 2,
  parameter int DR_W = 38,
  parameter int NCH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                capture,
  input  logic                shift,
  input  logic                tdi,
  input  logic [IR_W-1:0]     sel,
  input  logic [NCH*DR_W-1:0] capture_data,
  output logic [DR_W-1:0]     sr,
  output logic                tdo
);
  logic [DR_W-1:0] cap_word;

  assign cap_word = capture_data[int'(sel)*DR_W +: DR_W];
  assign tdo      = sr[0];

  // Capture has priority over a shift strobe in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)        sr <= '0;
    else if (capture) sr <= cap_word;
    else if (shift)   sr <= {tdi, sr[DR_W-1:1]};
  end
endmodule

// File: rtl/debug_scan_bridge.sv
// Generic virtual-JTAG debug scan engine: IR latch, capture/shift data path,
// and an acknowledged update handshake with per-channel action pulses.
module debug_scan_bridge
  import debug_scan_pkg::*;
#(
  parameter int IR_W = 2,
  parameter int DR_W = 38,
  parameter int NCH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tck_en,
  input  logic                tdi,
  output logic                tdo,
  input  logic [IR_W-1:0]     ir_in,
  output logic [IR_W-1:0]     ir_out,
  input  logic                vs_cdr,
  input  logic                vs_sdr,
  input  logic                vs_udr,
  input  logic                vs_uir,
  input  logic                jtag_state_rti,
  input  logic [NCH*DR_W-1:0] capture_data,
  output logic [DR_W-1:0]     jdo,
  output logic [NCH-1:0]      take_action,
  output logic [NCH-1:0]      take_no_action,
  input  logic                action_ack,
  output logic                update_pending,
  output logic                overrun,
  output logic                st_ready_test_idle
);
  if (NCH != 2**IR_W) begin : g_chk_nch
    $error("debug_scan_bridge: NCH must equal 2**IR_W");
  end
  if (IR_W < IR_W_MIN || DR_W < DR_W_MIN) begin : g_chk_width
    $error("debug_scan_bridge: IR_W or DR_W below minimum");
  end

  logic [IR_W-1:0] ir_q;
  logic [DR_W-1:0] sr;
  upd_state_t      state, state_nxt;
  logic            pending, accept;

  debug_scan_shreg #(.IR_W(IR_W), .DR_W(DR_W), .NCH(NCH)) u_shreg (
    .clk          (clk),
    .reset        (reset),
    .capture      (vs_cdr),
    .shift        (vs_sdr && tck_en),
    .tdi          (tdi),
    .sel          (ir_q),
    .capture_data (capture_data),
    .sr           (sr),
    .tdo          (tdo)
  );

  // Any non-idle state means jdo holds a word the debug logic has not acked.
  assign pending        = (state != UPD_IDLE);
  assign accept         = vs_udr && (!pending || action_ack);
  assign update_pending = pending;

  always_comb begin
    state_nxt = state;
    unique case (state)
      UPD_IDLE:  if (accept) state_nxt = UPD_PULSE;
      UPD_PULSE: if (accept)          state_nxt = UPD_PULSE;
                 else if (action_ack) state_nxt = UPD_IDLE;
                 else                 state_nxt = UPD_WAIT;
      UPD_WAIT:  if (accept)          state_nxt = UPD_PULSE;
                 else if (action_ack) state_nxt = UPD_IDLE;
      default:   state_nxt = UPD_IDLE;
    endcase
  end

  always_comb begin
    ir_out              = '0;
    ir_out[IRO_PENDING] = pending;
    ir_out[IRO_OVERRUN] = overrun;
  end

  // A dropped update sets overrun even if vs_uir clears it in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= UPD_IDLE;
      ir_q               <= '0;
      jdo                <= '0;
      overrun            <= 1'b0;
      take_action        <= '0;
      take_no_action     <= '0;
      st_ready_test_idle <= 1'b0;
    end else begin
      state              <= state_nxt;
      st_ready_test_idle <= jtag_state_rti;
      take_action        <= '0;
      take_no_action     <= '0;
      if (vs_uir) begin
        ir_q    <= ir_in;
        overrun <= 1'b0;
      end
      if (vs_udr && !accept) overrun <= 1'b1;
      if (accept) begin
        jdo <= sr;
        if (sr[DR_W-1]) take_action[ir_q]    <= 1'b1;
        else            take_no_action[ir_q] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_debug_scan_bridge.sv
// Scoreboard bench: directed and random JTAG strobe traffic against a
// behavioural model; a negedge monitor pops expected update pulses.
module tb_debug_scan_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default build: IR_W=2, DR_W=38, NCH=4
  logic        reset, tck_en, tdi, vs_cdr, vs_sdr, vs_udr, vs_uir, rti, ack;
  logic [1:0]  ir_in, ir_out;
  logic [37:0] cap [4];
  logic [151:0] capture_data;
  logic [37:0] jdo;
  logic [3:0]  take_action, take_no_action;
  logic        tdo, update_pending, overrun, st_rti;

  assign capture_data = {cap[3], cap[2], cap[1], cap[0]};

  debug_scan_bridge dut (
    .clk(clk), .reset(reset), .tck_en(tck_en), .tdi(tdi), .tdo(tdo),
    .ir_in(ir_in), .ir_out(ir_out), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .jtag_state_rti(rti),
    .capture_data(capture_data), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .action_ack(ack),
    .update_pending(update_pending), .overrun(overrun),
    .st_ready_test_idle(st_rti)
  );

  // Generic build: IR_W=3, DR_W=16, NCH=8
  logic        r2, tck2, tdi2, cdr2, sdr2, udr2, uir2, rti2, ack2;
  logic [2:0]  ir_in2, ir_out2;
  logic [127:0] cap2;
  logic [15:0] jdo2;
  logic [7:0]  ta2, tna2;
  logic        tdo2, pend2, ovr2, st2;

  debug_scan_bridge #(.IR_W(3), .DR_W(16), .NCH(8)) dut2 (
    .clk(clk), .reset(r2), .tck_en(tck2), .tdi(tdi2), .tdo(tdo2),
    .ir_in(ir_in2), .ir_out(ir_out2), .vs_cdr(cdr2), .vs_sdr(sdr2),
    .vs_udr(udr2), .vs_uir(uir2), .jtag_state_rti(rti2),
    .capture_data(cap2), .jdo(jdo2), .take_action(ta2),
    .take_no_action(tna2), .action_ack(ack2),
    .update_pending(pend2), .overrun(ovr2), .st_ready_test_idle(st2)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [37:0] word;
    logic        act;
    logic [1:0]  ch;
  } exp_t;
  exp_t sbq[$];

  // Behavioural model state
  logic [1:0]  m_ir;
  logic [37:0] m_sr, m_jdo;
  logic        m_pend, m_ovr, m_rti;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic uir, input logic cdr,
                       input logic sdr, input logic tck, input logic tdi_v,
                       input logic udr, input logic a, input logic [1:0] irv);
    logic [37:0] nsr;
    logic        acc, r;
    r = 1'($urandom_range(0, 1));
    reset = rst; vs_uir = uir; vs_cdr = cdr; vs_sdr = sdr; tck_en = tck;
    tdi = tdi_v; vs_udr = udr; ack = a; ir_in = irv; rti = r;
    if (rst) begin
      m_ir = '0; m_sr = '0; m_jdo = '0; m_pend = 0; m_ovr = 0; m_rti = 0;
    end else begin
      nsr = m_sr;
      if (cdr) nsr = cap[m_ir];
      else if (sdr && tck) nsr = (m_sr >> 1) | (38'(tdi_v) << 37);
      acc = udr && (!m_pend || a);
      if (uir) m_ovr = 0;
      if (acc) begin
        sbq.push_back('{word: m_sr, act: m_sr[37], ch: m_ir});
        m_jdo = m_sr; m_pend = 1;
      end else if (udr) m_ovr = 1;
      else if (a) m_pend = 0;
      if (uir) m_ir = irv;
      m_sr = nsr; m_rti = r;
    end
    @(posedge clk); #1;
    chk("tdo", tdo, m_sr[0]);
    chk("jdo", jdo, m_jdo);
    chk("pending", update_pending, m_pend);
    chk("overrun", overrun, m_ovr);
    chk("ir_out", ir_out, {m_ovr, m_pend});
    chk("st_ready", st_rti, m_rti);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
  endtask

  task automatic shift_word(input logic [37:0] w);
    logic [37:0] v;
    v = w;
    for (int i = 0; i < 38; i++) drive(0, 0, 0, 1, 1, v[i], 0, 0, 2'd0);
  endtask

  // Monitor: every visible pulse must match the next expected update.
  always @(negedge clk) begin
    if ((take_action | take_no_action) != 4'd0) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse: ta=%b tna=%b", take_action, take_no_action);
      end else begin
        exp_t e;
        logic [3:0] oh;
        e  = sbq.pop_front();
        oh = 4'b0001 << e.ch;
        chk("sb_take_action", take_action, e.act ? oh : 4'd0);
        chk("sb_take_no_action", take_no_action, e.act ? 4'd0 : oh);
        chk("sb_jdo", jdo, e.word);
      end
    end
  end

  initial begin
    logic [37:0] w;
    for (int k = 0; k < 4; k++) cap[k] = '0;
    cap[2] = 38'h2A_5555_AAAA;
    r2 = 1; tck2 = 0; tdi2 = 0; cdr2 = 0; sdr2 = 0; udr2 = 0; uir2 = 0;
    rti2 = 0; ack2 = 0; ir_in2 = 0; cap2 = '0;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    chk("reset_ta", take_action, 4'd0);
    chk("reset_tna", take_no_action, 4'd0);

    // Capture ch2 and shift it out with tdi=0
    drive(0, 1, 0, 0, 0, 0, 0, 0, 2'd2);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 2'd0);
    w = 38'h2A_5555_AAAA;
    chk("tdo_stream_0", tdo, w[0]);
    for (int i = 1; i < 38; i++) begin
      drive(0, 0, 0, 1, 1, 0, 0, 0, 2'd0);
      chk("tdo_stream", tdo, w[i]);
    end
    drive(0, 0, 0, 1, 1, 0, 0, 0, 2'd0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 2'd0);
    chk("sr_drained_jdo", jdo, 38'd0);
    chk("drained_tna", take_no_action, 4'b0100);

    // Action on ch1
    drive(0, 1, 0, 0, 0, 0, 0, 1, 2'd1);
    shift_word(38'h20_0000_0001);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 2'd0);
    chk("act_jdo", jdo, 38'h20_0000_0001);
    chk("act_pulse", take_action, 4'b0010);
    idle();
    chk("act_one_cycle", take_action, 4'd0);

    // No-action after ack
    drive(0, 0, 0, 0, 0, 0, 0, 1, 2'd0);
    shift_word(38'h00_0000_0005);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 2'd0);
    chk("noact_pulse", take_no_action, 4'b0010);

    // Overrun: second update without ack is dropped
    shift_word(38'h3F_0000_1234);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 2'd0);
    chk("ovr_jdo_held", jdo, 38'h00_0000_0005);
    chk("ovr_ir_out", ir_out, 2'b11);
    chk("ovr_no_pulse", take_action | take_no_action, 4'd0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 2'd1);
    chk("ovr_cleared", overrun, 1'b0);

    // Update together with ack while pending
    drive(0, 0, 0, 0, 0, 0, 1, 1, 2'd0);
    chk("udr_ack_jdo", jdo, 38'h3F_0000_1234);
    chk("udr_ack_pulse", take_action, 4'b0010);

    // Capture beats shift
    cap[1] = 38'h12_3456_7891;
    drive(0, 0, 1, 1, 1, 1, 0, 0, 2'd0);
    chk("cap_wins", tdo, 1'b1);

    // Reset mid-shift
    drive(0, 0, 0, 0, 0, 0, 0, 1, 2'd0);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 1, 1, 0, 0, 2'd0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 2'd0);
    drive(1, 0, 0, 1, 1, 1, 1, 0, 2'd0);
    chk("rst_tdo", tdo, 1'b0);
    chk("rst_pending", update_pending, 1'b0);
    repeat (3) idle();
    chk("rst_no_pulse", take_action | take_no_action, 4'd0);

    // Random traffic
    for (int k = 0; k < 4; k++) cap[k] = {6'($urandom), 32'($urandom)};
    begin
      logic sdr_lvl;
      sdr_lvl = 0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 9) == 0) sdr_lvl = ~sdr_lvl;
        drive($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 9) == 0, sdr_lvl, 1'($urandom),
              1'($urandom), $urandom_range(0, 6) == 0,
              $urandom_range(0, 6) == 0, 2'($urandom));
      end
    end
    idle(); idle();
    chk("sb_drained", sbq.size(), 0);

    // Generic build, update on ch7
    cap2[7*16 +: 16] = 16'h8001;
    @(posedge clk); #1;
    r2 = 0; uir2 = 1; ir_in2 = 3'd7;
    @(posedge clk); #1;
    uir2 = 0; cdr2 = 1;
    @(posedge clk); #1;
    cdr2 = 0; udr2 = 1;
    @(posedge clk); #1;
    udr2 = 0;
    chk("g_take_action", ta2, 8'h80);
    chk("g_jdo", jdo2, 16'h8001);
    chk("g_ir_out", ir_out2, 3'b001);
    @(posedge clk); #1;
    chk("g_one_cycle", ta2 | tna2, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
